// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing arbiter: operand widths, ALU op codes and
// the state encoding of the single-entry result slot.
package alu_share_pkg;

   localparam int ALU_W    = 32;
   localparam int ALU_OP_W = 2;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
   localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b11;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Generic round-robin arbiter: one-hot grant searching from an internal pointer,
// which moves just past the winner whenever a grant is actually given.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 en,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id
);

   localparam int IDW = $clog2(N);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] idx;
   logic           found;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         idx = IDW'((int'(ptr) + k) % N);
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = idx;
         end
      end
   end

   // Pointer wraps explicitly so non-power-of-two N never lands on an unused index
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NREQ requesters: round-robin grant,
// operand mux onto the ALU bus, and a single registered result slot with handshake.
module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*ALU_W-1:0]     req_a,
   input  logic [NREQ*ALU_W-1:0]     req_b,
   input  logic [NREQ*ALU_OP_W-1:0]  req_op,
   output logic [ALU_W-1:0]          alu_a,
   output logic [ALU_W-1:0]          alu_b,
   output logic [ALU_OP_W-1:0]       alu_op,
   input  logic [ALU_W-1:0]          alu_y,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [ALU_W-1:0]          rsp_y
);

   localparam int IDW = $clog2(NREQ);

   slot_state_t     state;
   slot_state_t     state_next;
   logic            can_issue;
   logic            issue;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_id;

   // Reset also blocks the grant so a handshake seen during reset never completes
   assign can_issue = (state == SLOT_EMPTY) || rsp_ready;
   assign issue     = |gnt;
   assign req_ready = gnt;
   assign rsp_valid = (state == SLOT_FULL);

   rr_arbiter #(
      .N (NREQ)
   ) u_rr (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_valid),
      .en     (can_issue && rst_n),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = ALU_ADD;
      if (issue) begin
         alu_a  = req_a[ALU_W*gnt_id +: ALU_W];
         alu_b  = req_b[ALU_W*gnt_id +: ALU_W];
         alu_op = req_op[ALU_OP_W*gnt_id +: ALU_OP_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= SLOT_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // A refill on the same edge as a drain keeps the slot full for 1 op/clk throughput
   always_comb begin
      state_next = state;
      if (issue) begin
         state_next = SLOT_FULL;
      end else if (rsp_ready) begin
         state_next = SLOT_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_y  <= '0;
         rsp_id <= '0;
      end else if (issue) begin
         rsp_y  <= alu_y;
         rsp_id <= gnt_id;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level model of the arbiter and result slot.
module tb_alu_share_arbiter;
   import alu_share_pkg::*;

   localparam int NREQ = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*32-1:0]   req_a;
   logic [NREQ*32-1:0]   req_b;
   logic [NREQ*2-1:0]    req_op;
   logic [31:0]          alu_a;
   logic [31:0]          alu_b;
   logic [1:0]           alu_op;
   logic [31:0]          alu_y;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [1:0]           rsp_id;
   logic [31:0]          rsp_y;

   int passes = 0;
   int checks = 0;

   int          m_ptr;
   bit          m_valid;
   logic [31:0] m_y;
   int          m_id;
   int          m_grant;

   always #5 clk = ~clk;

   alu_share_arbiter #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_y     (alu_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y)
   );

   function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [1:0] op);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         default: return a | b;
      endcase
   endfunction

   // External ALU stand-in
   assign alu_y = alu_ref(alu_a, alu_b, alu_op);

   function automatic int pick(int ptr, logic [NREQ-1:0] v, bit can);
      int j;
      if (!can) return -1;
      for (int k = 0; k < NREQ; k++) begin
         j = (ptr + k) % NREQ;
         if (v[j[1:0]]) return j;
      end
      return -1;
   endfunction

   task automatic set_req(int i, bit v, logic [31:0] a, logic [31:0] b, logic [1:0] op);
      req_valid[i]       = v;
      req_a[32*i +: 32]  = a;
      req_b[32*i +: 32]  = b;
      req_op[2*i +: 2]   = op;
   endtask

   task automatic advance();
      bit can;
      can     = rst_n && (!m_valid || rsp_ready);
      m_grant = pick(m_ptr, req_valid, can);
      if (!rst_n) begin
         m_valid = 1'b0;
         m_y     = '0;
         m_id    = 0;
         m_ptr   = 0;
      end else if (m_grant >= 0) begin
         m_valid = 1'b1;
         m_y     = alu_ref(req_a[32*m_grant +: 32], req_b[32*m_grant +: 32], req_op[2*m_grant +: 2]);
         m_id    = m_grant;
         m_ptr   = (m_grant + 1) % NREQ;
      end else if (m_valid && rsp_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'(i), 32'd1, ALU_ADD);
      #1;
      checks++;
      if (req_ready !== 4'b0000) $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready);
      else passes++;
      advance();
      advance();
      checks++;
      if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
      else passes++;
      checks++;
      if (rsp_y !== 32'd0 || rsp_id !== 2'd0)
         $display("[TB] FAIL reset_rsp_data: got y=%h id=%0d expected y=0 id=0", rsp_y, rsp_id);
      else passes++;
   endtask

   task automatic test_single_op();
      req_valid = '0;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      set_req(0, 1'b1, 32'd5, 32'd3, ALU_SUB);
      #1;
      checks++;
      if (req_ready !== 4'b0001) $display("[TB] FAIL single_ready: got %b expected 0001", req_ready);
      else passes++;
      checks++;
      if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== ALU_SUB)
         $display("[TB] FAIL single_alu_bus: got a=%h b=%h op=%b expected a=5 b=3 op=01", alu_a, alu_b, alu_op);
      else passes++;
      advance();
      req_valid = '0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_y !== 32'd2 || rsp_id !== 2'd0)
         $display("[TB] FAIL single_result: got v=%b y=%h id=%0d expected v=1 y=2 id=0", rsp_valid, rsp_y, rsp_id);
      else passes++;
      #1;
      checks++;
      if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 2'b00)
         $display("[TB] FAIL quiet_bus: got a=%h b=%h op=%b expected 0/0/00", alu_a, alu_b, alu_op);
      else passes++;
      advance();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_y !== 32'd2)
         $display("[TB] FAIL single_drain: got v=%b y=%h expected v=0 y=2", rsp_valid, rsp_y);
      else passes++;
   endtask

   task automatic test_round_robin();
      rst_n = 1'b0;
      advance();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'(i), 32'd10, ALU_ADD);
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (req_ready !== 4'(1 << (k % 4)))
            $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, req_ready, 4'(1 << (k % 4)));
         else passes++;
         advance();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_y !== 32'(10 + k % 4) || rsp_id !== 2'(k % 4))
            $display("[TB] FAIL rr_result%0d: got v=%b y=%h id=%0d expected v=1 y=%h id=%0d",
                     k, rsp_valid, rsp_y, rsp_id, 32'(10 + k % 4), k % 4);
         else passes++;
      end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_y !== 32'd10 || rsp_id !== 2'd0)
            $display("[TB] FAIL bp_hold%0d: got rdy=%b v=%b y=%h id=%0d expected rdy=0000 v=1 y=a id=0",
                     k, req_ready, rsp_valid, rsp_y, rsp_id);
         else passes++;
         advance();
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) $display("[TB] FAIL bp_release: got %b expected 0010", req_ready);
      else passes++;
      advance();
      checks++;
      if (rsp_y !== 32'd11 || rsp_id !== 2'd1)
         $display("[TB] FAIL bp_result: got y=%h id=%0d expected y=b id=1", rsp_y, rsp_id);
      else passes++;
   endtask

   task automatic test_wrap_ops();
      logic [31:0] va [4] = '{32'hFFFF_FFFF, 32'h0, 32'h0000_F0F0, 32'h0000_F0F0};
      logic [31:0] vb [4] = '{32'h1, 32'h1, 32'h0000_0FF0, 32'h0000_0FF0};
      logic [1:0]  vo [4] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR};
      logic [31:0] ve [4] = '{32'h0, 32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_FFF0};
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req_valid = '0;
         set_req(k, 1'b1, va[k], vb[k], vo[k]);
         #1;
         advance();
         checks++;
         if (rsp_y !== ve[k] || rsp_id !== 2'(k))
            $display("[TB] FAIL wrap_op%0d: got y=%h id=%0d expected y=%h id=%0d", k, rsp_y, rsp_id, ve[k], k);
         else passes++;
      end
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      advance();
      req_valid = '0;
      set_req(3, 1'b1, 32'd7, 32'd8, ALU_ADD);
      rsp_ready = 1'b1;
      advance();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_y !== 32'd15)
         $display("[TB] FAIL mid_setup: got v=%b y=%h expected v=1 y=f", rsp_valid, rsp_y);
      else passes++;
      rst_n = 1'b0;
      advance();
      checks++;
      if (rsp_valid !== 1'b0) $display("[TB] FAIL mid_reset_valid: got %b expected 0", rsp_valid);
      else passes++;
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 32'(i), 32'd1, ALU_ADD);
      #1;
      checks++;
      if (req_ready !== 4'b0001) $display("[TB] FAIL mid_first_grant: got %b expected 0001", req_ready);
      else passes++;
      rsp_ready = 1'b1;
      advance();
      req_valid = '0;
   endtask

   task automatic test_random();
      int          g;
      logic [3:0]  exp_rdy;
      int          wait_cnt [NREQ];
      int          max_wait [NREQ];
      for (int i = 0; i < NREQ; i++) begin
         wait_cnt[i] = 0;
         max_wait[i] = 0;
      end
      for (int c = 0; c < 400; c++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && ($urandom_range(0, 1) == 1))
               set_req(i, 1'b1, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                       $urandom, 2'($urandom_range(0, 3)));
         end
         #1;
         g       = pick(m_ptr, req_valid, rst_n && (!m_valid || rsp_ready));
         exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
         checks++;
         if (req_ready !== exp_rdy)
            $display("[TB] FAIL rand_ready c%0d: got %b expected %b", c, req_ready, exp_rdy);
         else passes++;
         checks++;
         if (g >= 0) begin
            if (alu_a !== req_a[32*g +: 32] || alu_b !== req_b[32*g +: 32] || alu_op !== req_op[2*g +: 2])
               $display("[TB] FAIL rand_bus c%0d: got a=%h b=%h op=%b expected a=%h b=%h op=%b", c,
                        alu_a, alu_b, alu_op, req_a[32*g +: 32], req_b[32*g +: 32], req_op[2*g +: 2]);
            else passes++;
         end else begin
            if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 2'b00)
               $display("[TB] FAIL rand_quiet c%0d: got a=%h b=%h op=%b expected 0/0/00", c, alu_a, alu_b, alu_op);
            else passes++;
         end
         checks++;
         if (rsp_valid !== m_valid || (m_valid && (rsp_y !== m_y || rsp_id !== 2'(m_id))))
            $display("[TB] FAIL rand_rsp c%0d: got v=%b y=%h id=%0d expected v=%b y=%h id=%0d",
                     c, rsp_valid, rsp_y, rsp_id, m_valid, m_y, m_id);
         else passes++;
         if (req_ready != 4'b0000) begin
            for (int i = 0; i < NREQ; i++) begin
               if (req_ready[i]) wait_cnt[i] = 0;
               else if (req_valid[i]) begin
                  wait_cnt[i]++;
                  if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
               end
            end
         end
         advance();
         if (m_grant >= 0) req_valid[m_grant] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
         checks++;
         if (max_wait[i] > NREQ - 1)
            $display("[TB] FAIL fairness_req%0d: got wait %0d expected at most %0d", i, max_wait[i], NREQ - 1);
         else passes++;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b0;
      m_ptr     = 0;
      m_valid   = 1'b0;
      m_y       = '0;
      m_id      = 0;
      m_grant   = -1;
      test_reset();
      test_single_op();
      test_round_robin();
      test_backpressure();
      test_wrap_ops();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
